// File: rtl/iob_eth_cfg_seq.sv
// Configuration sequencer: buffers register commands in a small FIFO and plays
// them one at a time onto the Ethernet MAC native bus, returning read data or a timeout flag.
module iob_eth_cfg_seq #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                busy_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]   FULL_COUNT    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TIMEOUT_COUNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t state;

  logic [ADDR_W-1:0] addr_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] wdata_mem [FIFO_DEPTH];
  logic [STRB_W-1:0] wstrb_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;

  assign cmd_ready_o   = (count != FULL_COUNT);
  assign push          = cmd_valid_i && cmd_ready_o;
  assign pop           = (state == IDLE) && (count != '0);
  assign busy_o        = (count != '0) || (state != IDLE);
  assign wait_cnt_next = wait_cnt + 1'b1;

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr]  <= cmd_addr_i;
      wdata_mem[wr_ptr] <= cmd_wdata_i;
      wstrb_mem[wr_ptr] <= cmd_wstrb_i;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= IDLE;
      valid_o     <= 1'b0;
      address_o   <= '0;
      wdata_o     <= '0;
      wstrb_o     <= '0;
      wait_cnt    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            address_o <= addr_mem[rd_ptr];
            wdata_o   <= wdata_mem[rd_ptr];
            wstrb_o   <= wstrb_mem[rd_ptr];
            valid_o   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          valid_o <= 1'b0;
          if (ready_i) begin
            rsp_rdata_o <= rdata_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            wstrb_o     <= '0;
            state       <= RSP;
          end else begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A ready arriving on the final count still completes normally.
          if (ready_i) begin
            rsp_rdata_o <= rdata_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            wstrb_o     <= '0;
            state       <= RSP;
          end else if (wait_cnt_next == TIMEOUT_COUNT) begin
            wait_cnt    <= wait_cnt_next;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            wstrb_o     <= '0;
            state       <= RSP;
          end else begin
            wait_cnt <= wait_cnt_next;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_cfg_seq.sv
// Testbench for iob_eth_cfg_seq: a vector table for single transactions, then
// hand-written sequences for timeout, FIFO fill, response back-pressure and reset abort.
module tb_iob_eth_cfg_seq;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        valid;
  logic [11:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  logic [11:0] seen_addr [$];

  typedef struct {
    logic        cmd_valid;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        rsp_ready;
  } stim_t;

  typedef struct {
    logic        cmd_ready;
    logic        valid;
    logic [11:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
  } exp_t;

  typedef struct {
    stim_t stim;
    exp_t  exp;
  } vec_t;

  iob_eth_cfg_seq #(
    .ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .valid_o(valid), .address_o(address), .wdata_o(wdata), .wstrb_o(wstrb),
    .rdata_i(rdata), .ready_i(ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Bus request monitor: counts valid pulses and logs their addresses in order.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_count++;
      seen_addr.push_back(address);
    end
  end

  function automatic stim_t mkStim(input logic cv, input logic [11:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input logic r, input logic [31:0] rd,
                                   input logic rr);
    stim_t t;
    t.cmd_valid = cv; t.cmd_addr = a; t.cmd_wdata = d; t.cmd_wstrb = s;
    t.ready = r; t.rdata = rd; t.rsp_ready = rr;
    return t;
  endfunction

  function automatic exp_t mkExp(input logic cr, input logic v, input logic [11:0] a,
                                 input logic [31:0] d, input logic [3:0] s, input logic rv,
                                 input logic [31:0] rd, input logic er, input logic b);
    exp_t e;
    e.cmd_ready = cr; e.valid = v; e.address = a; e.wdata = d; e.wstrb = s;
    e.rsp_valid = rv; e.rsp_rdata = rd; e.rsp_err = er; e.busy = b;
    return e;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input exp_t e);
    vec_t v;
    v.stim = s; v.exp = e;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    cmd_valid = s.cmd_valid;
    cmd_addr  = s.cmd_addr;
    cmd_wdata = s.cmd_wdata;
    cmd_wstrb = s.cmd_wstrb;
    ready     = s.ready;
    rdata     = s.rdata;
    rsp_ready = s.rsp_ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input string name, input exp_t e);
    checkOutput({name, ".cmd_ready"}, 32'(cmd_ready), 32'(e.cmd_ready));
    checkOutput({name, ".valid"},     32'(valid),     32'(e.valid));
    checkOutput({name, ".address"},   32'(address),   32'(e.address));
    checkOutput({name, ".wdata"},     wdata,          e.wdata);
    checkOutput({name, ".wstrb"},     32'(wstrb),     32'(e.wstrb));
    checkOutput({name, ".rsp_valid"}, 32'(rsp_valid), 32'(e.rsp_valid));
    checkOutput({name, ".rsp_rdata"}, rsp_rdata,      e.rsp_rdata);
    checkOutput({name, ".rsp_err"},   32'(rsp_err),   32'(e.rsp_err));
    checkOutput({name, ".busy"},      32'(busy),      32'(e.busy));
  endtask

  task automatic waitValid(input string name);
    bit found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL %s: got no valid_o within 20 cycles, expected a request", name);
    end
  endtask

  task automatic consumeResponse();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got no completion, expected the run to finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [11];
    stim_t       idle_s;
    exp_t        reset_e;
    int          snap;
    int          base_q;
    int          bad;
    logic [11:0] fill_addr [6];
    logic        fill_ready [6];
    logic [11:0] got;

    idle_s  = mkStim(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    reset_e = mkExp(1'b1, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Write with a two-cycle bus wait, read completing in REQ, then ready ignored in IDLE.
    vecs[0]  = mkVec(mkStim(1'b1, 12'h000, 32'h0000A080, 4'hF, 1'b0, 32'h0, 1'b0),
                     mkExp(1'b1, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1));
    vecs[1]  = mkVec(idle_s, mkExp(1'b1, 1'b1, 12'h000, 32'h0000A080, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1));
    vecs[2]  = mkVec(idle_s, mkExp(1'b1, 1'b0, 12'h000, 32'h0000A080, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1));
    vecs[3]  = mkVec(idle_s, mkExp(1'b1, 1'b0, 12'h000, 32'h0000A080, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1));
    vecs[4]  = mkVec(mkStim(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0),
                     mkExp(1'b1, 1'b0, 12'h000, 32'h0000A080, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1));
    vecs[5]  = mkVec(mkStim(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1),
                     mkExp(1'b1, 1'b0, 12'h000, 32'h0000A080, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0));
    vecs[6]  = mkVec(mkStim(1'b1, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0),
                     mkExp(1'b1, 1'b0, 12'h000, 32'h0000A080, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1));
    vecs[7]  = mkVec(idle_s, mkExp(1'b1, 1'b1, 12'h000, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1));
    vecs[8]  = mkVec(mkStim(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 32'h0000A480, 1'b0),
                     mkExp(1'b1, 1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 32'h0000A480, 1'b0, 1'b1));
    vecs[9]  = mkVec(mkStim(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1),
                     mkExp(1'b1, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0000A480, 1'b0, 1'b0));
    vecs[10] = mkVec(mkStim(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 32'h00000055, 1'b0),
                     mkExp(1'b1, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0000A480, 1'b0, 1'b0));

    fill_addr  = '{12'h604, 12'h600, 12'h000, 12'h404, 12'h400, 12'h7FF};
    fill_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    arst_n = 1'b0;
    applyStimulus(idle_s);
    #2;
    checkVector("reset", reset_e);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].stim);
      @(negedge clk);
      checkVector($sformatf("vec%0d", i), vecs[i].exp);
    end
    applyStimulus(idle_s);

    $display("[TB] timeout with ready held low");
    snap = valid_count;
    cmd_valid = 1'b1; cmd_addr = 12'h123; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    waitValid("timeout.req");
    checkOutput("timeout.req_addr", 32'(address), 32'h123);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("timeout.wait%0d_rsp_valid", k), 32'(rsp_valid), 32'h0);
      checkOutput($sformatf("timeout.wait%0d_addr", k), 32'(address), 32'h123);
    end
    @(negedge clk);
    checkOutput("timeout.rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("timeout.rsp_err", 32'(rsp_err), 32'h1);
    checkOutput("timeout.rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("timeout.valid_pulses", 32'(valid_count - snap), 32'h1);
    consumeResponse();
    checkOutput("timeout.busy_after", 32'(busy), 32'h0);

    $display("[TB] ready on the final wait cycle");
    cmd_valid = 1'b1; cmd_addr = 12'h124;
    @(negedge clk);
    cmd_valid = 1'b0;
    waitValid("late_ready.req");
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) begin
        ready = 1'b1;
        rdata = 32'hCAFE0001;
      end
    end
    @(negedge clk);
    ready = 1'b0;
    checkOutput("late_ready.rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("late_ready.rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("late_ready.rsp_rdata", rsp_rdata, 32'hCAFE0001);
    consumeResponse();

    $display("[TB] FIFO fill with bus stalled");
    snap   = valid_count;
    base_q = seen_addr.size();
    for (int j = 0; j < 6; j++) begin
      cmd_valid = 1'b1; cmd_addr = fill_addr[j]; cmd_wdata = 32'(j); cmd_wstrb = 4'hF;
      @(negedge clk);
      checkOutput($sformatf("fill.push%0d_cmd_ready", j), 32'(cmd_ready), 32'(fill_ready[j]));
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) waitValid($sformatf("fill.req%0d", i));
      ready = 1'b1;
      rdata = 32'hA0000000 | 32'(fill_addr[i]);
      @(negedge clk);
      ready = 1'b0;
      checkOutput($sformatf("fill.rsp%0d_valid", i), 32'(rsp_valid), 32'h1);
      checkOutput($sformatf("fill.rsp%0d_rdata", i), rsp_rdata, 32'hA0000000 | 32'(fill_addr[i]));
      checkOutput($sformatf("fill.rsp%0d_err", i), 32'(rsp_err), 32'h0);
      consumeResponse();
    end
    repeat (3) @(negedge clk);
    checkOutput("fill.valid_pulses", 32'(valid_count - snap), 32'h5);
    for (int i = 0; i < 5; i++) begin
      got = (seen_addr.size() > base_q + i) ? seen_addr[base_q + i] : 12'hFFF;
      checkOutput($sformatf("fill.order%0d", i), 32'(got), 32'(fill_addr[i]));
    end
    checkOutput("fill.busy_after", 32'(busy), 32'h0);
    checkOutput("fill.cmd_ready_after", 32'(cmd_ready), 32'h1);

    $display("[TB] response back-pressure");
    cmd_valid = 1'b1; cmd_addr = 12'h010; cmd_wstrb = 4'h0;
    @(negedge clk);
    cmd_addr = 12'h020;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("hold.req_valid", 32'(valid), 32'h1);
    ready = 1'b1; rdata = 32'h00000011;
    @(negedge clk);
    ready = 1'b0;
    checkOutput("hold.rsp_valid", 32'(rsp_valid), 32'h1);
    snap = valid_count;
    bad  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11 || valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    checkOutput("hold.unstable_cycles", 32'(bad), 32'h0);
    checkOutput("hold.no_new_request", 32'(valid_count - snap), 32'h0);
    consumeResponse();
    @(negedge clk);
    checkOutput("hold.next_valid", 32'(valid), 32'h1);
    checkOutput("hold.next_addr", 32'(address), 32'h020);
    ready = 1'b1; rdata = 32'h00000022;
    @(negedge clk);
    ready = 1'b0;
    checkOutput("hold.next_rdata", rsp_rdata, 32'h00000022);
    consumeResponse();

    $display("[TB] reset abort mid-wait");
    for (int j = 0; j < 4; j++) begin
      cmd_valid = 1'b1;
      cmd_addr  = (j == 0) ? 12'h0AB : 12'h0AF + 12'(j);
      cmd_wdata = 32'h00001234;
      cmd_wstrb = 4'h3;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checkOutput("abort.pre_addr", 32'(address), 32'h0AB);
    checkOutput("abort.pre_wstrb", 32'(wstrb), 32'h3);
    #2;
    arst_n = 1'b0;
    #1;
    checkVector("abort", reset_e);
    @(negedge clk);
    arst_n = 1'b1;
    snap = valid_count;
    bad  = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checkOutput("abort.quiet_cycles", 32'(bad), 32'h0);
    checkOutput("abort.no_request", 32'(valid_count - snap), 32'h0);
    checkOutput("abort.cmd_ready", 32'(cmd_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_eth_cfg_seq.md
IOB_ETH_CFG_SEQ -- requirements
Module: iob_eth_cfg_seq

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 12, native-bus address width; DATA_W, default 32, data width; FIFO_DEPTH, default 4, command FIFO entries (power of 2); TIMEOUT, default 255, maximum wait cycles for ready.
REQ-002 The block SHALL have these ports, one per line as name  direction  width  meaning:
- clk_i  in  1  single clock; all logic on rising edge.
- arst_n_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command FIFO not full.
- cmd_addr_i  in  ADDR_W  register address.
- cmd_wdata_i  in  DATA_W  write data.
- cmd_wstrb_i  in  DATA_W/8  byte strobes; all-zero means read.
- valid_o  out  1  native-bus request to the Ethernet MAC wrapper.
- address_o  out  ADDR_W  bus address.
- wdata_o  out  DATA_W  bus write data.
- wstrb_o  out  DATA_W/8  bus strobes.
- rdata_i  in  DATA_W  bus read data.
- ready_i  in  1  bus completion.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_W  captured read data.
- rsp_err_o  out  1  timeout flag.
- busy_o  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-003 The block SHALL accept a command on any rising edge where cmd_valid_i and cmd_ready_o are both 1, storing {addr, wdata, wstrb} in a FIFO_DEPTH-entry FIFO.
REQ-004 cmd_ready_o SHALL be 0 exactly when the FIFO holds FIFO_DEPTH entries; a push while full SHALL be dropped with no state change.
REQ-005 Simultaneous push and pop on a full FIFO SHALL NOT be accepted (cmd_ready_o is already 0); simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged.
REQ-006 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-007 The FSM SHALL have four states: IDLE, REQ, WAIT, RSP.
REQ-008 IDLE: when the FIFO is non-empty, the FSM SHALL pop the head into the bus registers and go to REQ on the next edge.
REQ-009 REQ: valid_o SHALL be 1 for exactly this one cycle.
REQ-010 address_o, wdata_o and wstrb_o SHALL be held stable from REQ until the FSM leaves WAIT.
REQ-011 From REQ the FSM SHALL go to RSP if ready_i=1, otherwise to WAIT with the wait counter cleared.
REQ-012 In REQ and WAIT, on ready_i=1 the block SHALL capture rdata_i into rsp_rdata_o (for reads and writes alike), set rsp_err_o=0, and go to RSP.
REQ-013 WAIT: the wait counter SHALL increment each cycle with ready_i=0; when it reaches TIMEOUT the FSM SHALL go to RSP with rsp_err_o=1 and rsp_rdata_o=0.
REQ-014 If ready_i=1 in the same cycle the counter reaches TIMEOUT, ready SHALL win and rsp_err_o SHALL be 0.
REQ-015 wstrb_o SHALL be driven to 0 in every state except REQ and WAIT.
REQ-016 ready_i SHALL be ignored in IDLE and RSP.
REQ-017 RSP: rsp_valid_o SHALL be 1, with rsp_rdata_o and rsp_err_o stable, until rsp_ready_i=1, then the FSM SHALL go to IDLE.
REQ-018 Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE SHALL produce valid_o=1 in the cycle after edge N+1.
REQ-019 The block SHALL have at most one bus transaction outstanding; commands SHALL execute in FIFO order.
REQ-020 busy_o SHALL be combinational: 1 when the FIFO is non-empty or the FSM is not IDLE.

Reset
REQ-021 On arst_n_i=0 the block SHALL immediately reset: FSM to IDLE, FIFO empty, counter to 0, valid_o/wstrb_o/rsp_valid_o/rsp_err_o/busy_o to 0, address_o/wdata_o/rsp_rdata_o to 0, cmd_ready_o to 1.
REQ-022 Reset during REQ or WAIT SHALL abort the transaction without generating a response.
REQ-023 Reset release SHALL take effect on the first rising edge after arst_n_i rises.

Verification
REQ-024 Push write addr 0x000, data 0x0000A080, wstrb 0xF; bench asserts ready_i 2 cycles after valid_o -> one valid_o pulse; address_o and wdata_o held through WAIT; rsp_valid_o=1 with rsp_err_o=0.
REQ-025 Push read addr 0x000, wstrb 0x0; bench drives rdata_i=0x0000A480 with ready_i in the REQ cycle -> WAIT is skipped; rsp_rdata_o=0x0000A480.
REQ-026 With TIMEOUT=8 and ready_i held at 0 -> rsp_err_o=1 and rsp_rdata_o=0 after exactly 8 WAIT cycles; valid_o pulses only once.
REQ-027 Hold ready_i=0 and push 6 commands back-to-back -> 1 command is popped into the FSM, 4 are buffered, cmd_ready_o falls, and the 6th command is dropped; releasing the bus then yields 5 responses in order, with addresses 0x604, 0x600, 0x000, 0x404, 0x400 pushed in that order.
REQ-028 Hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o and rsp_rdata_o stay stable and no further valid_o is issued; on release the next command starts.
REQ-029 Assert arst_n_i=0 mid-WAIT with 3 commands queued -> all outputs immediately reach their reset values; after release, busy_o=0 and no response is emitted.
